// File: rtl/udma_eth_frame_pkg.sv
// Shared definitions for the uDMA ethernet frame config/status block:
// register map, FRAME_CTRL bit positions and the frame descriptor type.
package udma_eth_frame_pkg;

   localparam logic [4:0] REG_RX_SADDR   = 5'h00;
   localparam logic [4:0] REG_RX_SIZE    = 5'h01;
   localparam logic [4:0] REG_RX_CFG     = 5'h02;
   localparam logic [4:0] REG_WHOAMI     = 5'h03;
   localparam logic [4:0] REG_TX_SADDR   = 5'h04;
   localparam logic [4:0] REG_TX_SIZE    = 5'h05;
   localparam logic [4:0] REG_TX_CFG     = 5'h06;
   localparam logic [4:0] REG_FRAME_CTRL = 5'h07;
   localparam logic [4:0] REG_FIFO_N     = 5'h08;
   localparam logic [4:0] REG_FIFO_FULL  = 5'h09;
   localparam logic [4:0] REG_FRAME_STAT = 5'h0A;
   localparam logic [4:0] REG_FRAME_POP  = 5'h0B;
   localparam logic [4:0] REG_FRAME_CNT  = 5'h0C;

   localparam logic [31:0] WHOAMI_VALUE = 32'hDEADBEF2;

   localparam int CFG_CONT_BIT = 0;
   localparam int CFG_EN_BIT   = 4;
   localparam int CFG_CLR_BIT  = 6;

   localparam int CTRL_BLOCKED_BIT = 0;
   localparam int CTRL_IRQ_EN_BIT  = 1;
   localparam int CTRL_FLUSH_BIT   = 2;
   localparam int CTRL_OVF_BIT     = 3;

   // Descriptor length field is sized for the largest supported LEN_WIDTH.
   localparam int DESC_LEN_W = 30;

   typedef struct packed {
      logic                  err;
      logic [DESC_LEN_W-1:0] len;
   } eth_frame_desc_t;

   // Channel CFG read-back layout.
   function automatic logic [31:0] cfg_read_word(input logic pending,
                                                 input logic en,
                                                 input logic cont);
      return {26'h0, pending, en, 3'h0, cont};
   endfunction

endpackage

// File: rtl/udma_eth_frame_desc_q.sv
// Synchronous descriptor FIFO. A pop is applied before a push so a full
// queue can accept a new entry in the same cycle it releases its head.
// Flush overrides any push/pop in the same cycle.
module udma_eth_frame_desc_q
   import udma_eth_frame_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  eth_frame_desc_t          desc_i,
   output eth_frame_desc_t          head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [$clog2(DEPTH):0]   count_next_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic                     drop_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   eth_frame_desc_t    mem_r [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic [CNT_W-1:0]   count_next_s;
   logic               full_s;
   logic               empty_s;
   logic               pop_eff_s;
   logic               push_eff_s;
   logic               drop_s;

   // Decode effective push/pop and the next occupancy.
   always_comb begin
      full_s       = (count_r == CNT_W'(DEPTH));
      empty_s      = (count_r == {CNT_W{1'b0}});
      pop_eff_s    = pop_i & ~empty_s & ~flush_i;
      push_eff_s   = push_i & (~full_s | pop_eff_s) & ~flush_i;
      drop_s       = push_i & full_s & ~pop_eff_s & ~flush_i;
      count_next_s = count_r;
      if (flush_i) begin
         count_next_s = {CNT_W{1'b0}};
      end else if (push_eff_s && !pop_eff_s) begin
         count_next_s = count_r + CNT_W'(1);
      end else if (pop_eff_s && !push_eff_s) begin
         count_next_s = count_r - CNT_W'(1);
      end else begin
         count_next_s = count_r;
      end
   end

   // Pointer, count and storage update.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (flush_i) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         count_r <= count_next_s;
         if (pop_eff_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         if (push_eff_s) begin
            mem_r[wr_ptr_r] <= desc_i;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
      end
   end

   assign head_o       = mem_r[rd_ptr_r];
   assign count_o      = count_r;
   assign count_next_o = count_next_s;
   assign full_o       = full_s;
   assign empty_o      = empty_s;
   assign drop_o       = drop_s;

endmodule

// File: rtl/udma_eth_frame_reg_mq.sv
// uDMA ethernet frame configuration/status block with a multi-frame
// descriptor queue: channel registers, EOF edge detection, frame length
// counting, queue control, RX back-pressure and frame interrupt.
module udma_eth_frame_reg_mq
   import udma_eth_frame_pkg::*;
#(
   parameter int L2_AWIDTH_NOAL           = 12,
   parameter int TRANS_SIZE               = 16,
   parameter int RX_FIFO_BUFFER_DEPTH     = 1024,
   parameter int RX_FIFO_BUFFER_DEPTH_LOG = $clog2(RX_FIFO_BUFFER_DEPTH),
   parameter int FRAME_Q_DEPTH            = 4,
   parameter int LEN_WIDTH                = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [31:0]                       cfg_data_i,
   input  logic [4:0]                        cfg_addr_i,
   input  logic                              cfg_valid_i,
   input  logic                              cfg_rwn_i,
   output logic [31:0]                       cfg_data_o,
   output logic                              cfg_ready_o,
   output logic [L2_AWIDTH_NOAL-1:0]         cfg_rx_startaddr_o,
   output logic [TRANS_SIZE-1:0]             cfg_rx_size_o,
   output logic                              cfg_rx_continuous_o,
   output logic                              cfg_rx_en_o,
   output logic                              cfg_rx_clr_o,
   input  logic                              cfg_rx_en_i,
   input  logic                              cfg_rx_pending_i,
   input  logic [L2_AWIDTH_NOAL-1:0]         cfg_rx_curr_addr_i,
   input  logic [TRANS_SIZE-1:0]             cfg_rx_bytes_left_i,
   output logic [L2_AWIDTH_NOAL-1:0]         cfg_tx_startaddr_o,
   output logic [TRANS_SIZE-1:0]             cfg_tx_size_o,
   output logic                              cfg_tx_continuous_o,
   output logic                              cfg_tx_en_o,
   output logic                              cfg_tx_clr_o,
   input  logic                              cfg_tx_en_i,
   input  logic                              cfg_tx_pending_i,
   input  logic [L2_AWIDTH_NOAL-1:0]         cfg_tx_curr_addr_i,
   input  logic [TRANS_SIZE-1:0]             cfg_tx_bytes_left_i,
   input  logic                              rx_byte_valid_i,
   input  logic                              rx_eof_i,
   input  logic                              rx_err_i,
   input  logic [RX_FIFO_BUFFER_DEPTH_LOG:0] rx_fifo_elements_i,
   output logic                              rx_blocked_o,
   output logic                              irq_o
);

   localparam int CNT_W = $clog2(FRAME_Q_DEPTH) + 1;
   localparam int FE_W  = RX_FIFO_BUFFER_DEPTH_LOG + 1;
   localparam logic [LEN_WIDTH-1:0] LEN_MAX = {LEN_WIDTH{1'b1}};

   logic [L2_AWIDTH_NOAL-1:0] rx_saddr_r, tx_saddr_r;
   logic [TRANS_SIZE-1:0]     rx_size_r, tx_size_r;
   logic                      rx_cont_r, tx_cont_r;
   logic                      rx_en_r, rx_clr_r, tx_en_r, tx_clr_r;
   logic                      irq_en_r, ovf_r, eof_prev_r, blocked_r, irq_r;
   logic [LEN_WIDTH-1:0]      len_r;

   logic                      wr_s, eof_edge_s, len_inc_s;
   logic                      flush_s, pop_s, ovf_clr_s;
   logic [LEN_WIDTH-1:0]      len_plus_s;
   eth_frame_desc_t           push_desc_s, head_s;
   logic [CNT_W-1:0]          q_count_s, q_count_next_s;
   logic                      q_full_s, q_empty_s, q_drop_s;
   logic [31:0]               rdata_s;
   logic                      unused_ok_s;

   // Decode register writes and frame events for this cycle.
   always_comb begin
      wr_s        = cfg_valid_i & ~cfg_rwn_i;
      eof_edge_s  = rx_eof_i & ~eof_prev_r;
      len_inc_s   = rx_byte_valid_i & (len_r != LEN_MAX);
      len_plus_s  = len_inc_s ? (len_r + LEN_WIDTH'(1)) : len_r;
      flush_s     = wr_s & (cfg_addr_i == REG_FRAME_CTRL) & cfg_data_i[CTRL_FLUSH_BIT];
      ovf_clr_s   = wr_s & (cfg_addr_i == REG_FRAME_CTRL) & cfg_data_i[CTRL_OVF_BIT];
      pop_s       = wr_s & (cfg_addr_i == REG_FRAME_POP);
      push_desc_s.err = rx_err_i;
      push_desc_s.len = DESC_LEN_W'(len_plus_s);
   end

   udma_eth_frame_desc_q #(
      .DEPTH (FRAME_Q_DEPTH)
   ) i_desc_q (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_i       (eof_edge_s),
      .pop_i        (pop_s),
      .flush_i      (flush_s),
      .desc_i       (push_desc_s),
      .head_o       (head_s),
      .count_o      (q_count_s),
      .count_next_o (q_count_next_s),
      .full_o       (q_full_s),
      .empty_o      (q_empty_s),
      .drop_o       (q_drop_s)
   );

   // Channel registers and one-cycle enable/clear pulses.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_saddr_r <= {L2_AWIDTH_NOAL{1'b0}};
         tx_saddr_r <= {L2_AWIDTH_NOAL{1'b0}};
         rx_size_r  <= {TRANS_SIZE{1'b0}};
         tx_size_r  <= {TRANS_SIZE{1'b0}};
         rx_cont_r  <= 1'b0;
         tx_cont_r  <= 1'b0;
         rx_en_r    <= 1'b0;
         rx_clr_r   <= 1'b0;
         tx_en_r    <= 1'b0;
         tx_clr_r   <= 1'b0;
         irq_en_r   <= 1'b0;
      end else begin
         rx_en_r  <= 1'b0;
         rx_clr_r <= 1'b0;
         tx_en_r  <= 1'b0;
         tx_clr_r <= 1'b0;
         if (wr_s) begin
            case (cfg_addr_i)
               REG_RX_SADDR: rx_saddr_r <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
               REG_RX_SIZE:  rx_size_r  <= cfg_data_i[TRANS_SIZE-1:0];
               REG_RX_CFG: begin
                  rx_cont_r <= cfg_data_i[CFG_CONT_BIT];
                  rx_en_r   <= cfg_data_i[CFG_EN_BIT];
                  rx_clr_r  <= cfg_data_i[CFG_CLR_BIT];
               end
               REG_TX_SADDR: tx_saddr_r <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
               REG_TX_SIZE:  tx_size_r  <= cfg_data_i[TRANS_SIZE-1:0];
               REG_TX_CFG: begin
                  tx_cont_r <= cfg_data_i[CFG_CONT_BIT];
                  tx_en_r   <= cfg_data_i[CFG_EN_BIT];
                  tx_clr_r  <= cfg_data_i[CFG_CLR_BIT];
               end
               REG_FRAME_CTRL: irq_en_r <= cfg_data_i[CTRL_IRQ_EN_BIT];
               default: ;
            endcase
         end
      end
   end

   // Frame length counter, EOF edge history, overflow flag, blocked and irq.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         len_r      <= {LEN_WIDTH{1'b0}};
         eof_prev_r <= 1'b1;
         ovf_r      <= 1'b0;
         blocked_r  <= 1'b0;
         irq_r      <= 1'b0;
      end else begin
         eof_prev_r <= rx_eof_i;
         blocked_r  <= (q_count_next_s == CNT_W'(FRAME_Q_DEPTH));
         irq_r      <= irq_en_r & (q_count_next_s != {CNT_W{1'b0}});
         if (flush_s || eof_edge_s) begin
            len_r <= {LEN_WIDTH{1'b0}};
         end else begin
            len_r <= len_plus_s;
         end
         if (flush_s) begin
            ovf_r <= 1'b0;
         end else if (q_drop_s) begin
            ovf_r <= 1'b1;
         end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
         end
      end
   end

   // Combinational register read-back.
   always_comb begin
      rdata_s = 32'h0;
      case (cfg_addr_i)
         REG_RX_SADDR: rdata_s[L2_AWIDTH_NOAL-1:0] = cfg_rx_curr_addr_i;
         REG_RX_SIZE:  rdata_s[TRANS_SIZE-1:0]     = cfg_rx_bytes_left_i;
         REG_RX_CFG:   rdata_s = cfg_read_word(cfg_rx_pending_i, cfg_rx_en_i, rx_cont_r);
         REG_WHOAMI:   rdata_s = WHOAMI_VALUE;
         REG_TX_SADDR: rdata_s[L2_AWIDTH_NOAL-1:0] = cfg_tx_curr_addr_i;
         REG_TX_SIZE:  rdata_s[TRANS_SIZE-1:0]     = cfg_tx_bytes_left_i;
         REG_TX_CFG:   rdata_s = cfg_read_word(cfg_tx_pending_i, cfg_tx_en_i, tx_cont_r);
         REG_FRAME_CTRL: begin
            rdata_s[CTRL_BLOCKED_BIT] = blocked_r;
            rdata_s[CTRL_IRQ_EN_BIT]  = irq_en_r;
            rdata_s[CTRL_OVF_BIT]     = ovf_r;
         end
         REG_FIFO_N:    rdata_s[FE_W-1:0] = rx_fifo_elements_i;
         REG_FIFO_FULL: rdata_s[0] = (rx_fifo_elements_i == FE_W'(RX_FIFO_BUFFER_DEPTH));
         REG_FRAME_STAT: begin
            if (!q_empty_s) begin
               rdata_s[31]              = 1'b1;
               rdata_s[30]              = head_s.err;
               rdata_s[LEN_WIDTH-1:0]   = head_s.len[LEN_WIDTH-1:0];
            end else begin
               rdata_s = 32'h0;
            end
         end
         REG_FRAME_CNT: rdata_s[CNT_W-1:0] = q_count_s;
         default:       rdata_s = 32'h0;
      endcase
   end

   assign unused_ok_s = ^{cfg_data_i, head_s.len, q_full_s};

   assign cfg_data_o          = rdata_s;
   assign cfg_ready_o         = 1'b1;
   assign cfg_rx_startaddr_o  = rx_saddr_r;
   assign cfg_rx_size_o       = rx_size_r;
   assign cfg_rx_continuous_o = rx_cont_r;
   assign cfg_rx_en_o         = rx_en_r;
   assign cfg_rx_clr_o        = rx_clr_r;
   assign cfg_tx_startaddr_o  = tx_saddr_r;
   assign cfg_tx_size_o       = tx_size_r;
   assign cfg_tx_continuous_o = tx_cont_r;
   assign cfg_tx_en_o         = tx_en_r;
   assign cfg_tx_clr_o        = tx_clr_r;
   assign rx_blocked_o        = blocked_r;
   assign irq_o               = irq_r;

endmodule

// File: tb/tb_udma_eth_frame_reg_mq.sv
// Directed testbench for udma_eth_frame_reg_mq.
module tb_udma_eth_frame_reg_mq;
   import udma_eth_frame_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cfg_data_i = 32'h0;
   logic [4:0]  cfg_addr_i = 5'h0;
   logic        cfg_valid_i = 1'b0;
   logic        cfg_rwn_i = 1'b1;
   logic [31:0] cfg_data_o;
   logic        cfg_ready_o;
   logic [11:0] rx_sa, tx_sa;
   logic [15:0] rx_sz, tx_sz;
   logic        rx_cont, tx_cont, rx_en_o, rx_clr_o, tx_en_o, tx_clr_o;
   logic        rx_en_i = 1'b0, rx_pend_i = 1'b0, tx_en_i = 1'b0, tx_pend_i = 1'b0;
   logic [11:0] rx_curr = 12'h0, tx_curr = 12'h0;
   logic [15:0] rx_left = 16'h0, tx_left = 16'h0;
   logic        byte_valid = 1'b0, eof = 1'b1, err = 1'b0;
   logic [10:0] fifo_el = 11'd0;
   logic        blocked, irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   udma_eth_frame_reg_mq dut (
      .clk_i(clk), .rst_i(rst),
      .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i), .cfg_valid_i(cfg_valid_i),
      .cfg_rwn_i(cfg_rwn_i), .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
      .cfg_rx_startaddr_o(rx_sa), .cfg_rx_size_o(rx_sz), .cfg_rx_continuous_o(rx_cont),
      .cfg_rx_en_o(rx_en_o), .cfg_rx_clr_o(rx_clr_o),
      .cfg_rx_en_i(rx_en_i), .cfg_rx_pending_i(rx_pend_i),
      .cfg_rx_curr_addr_i(rx_curr), .cfg_rx_bytes_left_i(rx_left),
      .cfg_tx_startaddr_o(tx_sa), .cfg_tx_size_o(tx_sz), .cfg_tx_continuous_o(tx_cont),
      .cfg_tx_en_o(tx_en_o), .cfg_tx_clr_o(tx_clr_o),
      .cfg_tx_en_i(tx_en_i), .cfg_tx_pending_i(tx_pend_i),
      .cfg_tx_curr_addr_i(tx_curr), .cfg_tx_bytes_left_i(tx_left),
      .rx_byte_valid_i(byte_valid), .rx_eof_i(eof), .rx_err_i(err),
      .rx_fifo_elements_i(fifo_el),
      .rx_blocked_o(blocked), .irq_o(irq)
   );

   // All tasks start and end 1 time unit after a rising edge.
   task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
      cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = a; cfg_data_i = d;
      @(posedge clk); #1;
      cfg_valid_i = 1'b0; cfg_rwn_i = 1'b1; cfg_data_i = 32'h0;
   endtask

   task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
      cfg_valid_i = 1'b1; cfg_rwn_i = 1'b1; cfg_addr_i = a;
      #1 d = cfg_data_o;
      @(posedge clk); #1;
      cfg_valid_i = 1'b0;
   endtask

   // nbytes byte-valids, then an EOF pulse; last_in_eof moves the final byte into the EOF cycle.
   task automatic send_frame(input int nbytes, input logic e, input logic last_in_eof);
      int pre;
      pre = last_in_eof ? nbytes - 1 : nbytes;
      for (int i = 0; i < pre; i++) begin
         byte_valid = 1'b1; @(posedge clk); #1;
      end
      byte_valid = last_in_eof; eof = 1'b1; err = e;
      @(posedge clk); #1;
      byte_valid = 1'b0; eof = 1'b0; err = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      logic [31:0] rd;
      eof = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (blocked !== 1'b0 || irq !== 1'b0) begin errors++;
         $display("FAIL reset_out blocked=%b irq=%b exp 0 0", blocked, irq); end
      checks++; if (cfg_ready_o !== 1'b1 || rx_en_o !== 1'b0 || rx_clr_o !== 1'b0) begin errors++;
         $display("FAIL reset_cfg ready=%b en=%b clr=%b exp 1 0 0", cfg_ready_o, rx_en_o, rx_clr_o); end
      cfg_read(REG_WHOAMI, rd);
      checks++; if (rd !== 32'hDEADBEF2) begin errors++;
         $display("FAIL whoami got %h exp deadbef2", rd); end
      cfg_read(REG_FRAME_STAT, rd);
      checks++; if (rd !== 32'h0) begin errors++;
         $display("FAIL reset_stat got %h exp 0", rd); end
      cfg_read(REG_FRAME_CNT, rd);
      checks++; if (rd !== 32'h0) begin errors++;
         $display("FAIL reset_cnt got %h exp 0", rd); end
   endtask

   task automatic test_single_frame;
      logic [31:0] rd;
      cfg_write(REG_FRAME_CTRL, 32'h2);
      send_frame(64, 1'b0, 1'b0);
      cfg_read(REG_FRAME_STAT, rd);
      checks++; if (rd !== 32'h80000040) begin errors++;
         $display("FAIL single_stat got %h exp 80000040", rd); end
      cfg_read(REG_FRAME_CNT, rd);
      checks++; if (rd !== 32'h1) begin errors++;
         $display("FAIL single_cnt got %h exp 1", rd); end
      checks++; if (irq !== 1'b1) begin errors++;
         $display("FAIL single_irq got %b exp 1", irq); end
      cfg_write(REG_FRAME_POP, 32'h0);
      checks++; if (irq !== 1'b0) begin errors++;
         $display("FAIL pop_irq got %b exp 0", irq); end
      cfg_read(REG_FRAME_CNT, rd);
      checks++; if (rd !== 32'h0) begin errors++;
         $display("FAIL pop_cnt got %h exp 0", rd); end
   endtask

   task automatic test_queue_full;
      logic [31:0] rd;
      logic [31:0] exp_stat [4];
      exp_stat[0] = 32'h8000000A; exp_stat[1] = 32'h80000014;
      exp_stat[2] = 32'hC000001E; exp_stat[3] = 32'h80000028;
      send_frame(10, 1'b0, 1'b0);
      send_frame(20, 1'b0, 1'b0);
      send_frame(30, 1'b1, 1'b0);
      checks++; if (blocked !== 1'b0) begin errors++;
         $display("FAIL three_blocked got %b exp 0", blocked); end
      send_frame(40, 1'b0, 1'b1);
      checks++; if (blocked !== 1'b1) begin errors++;
         $display("FAIL full_blocked got %b exp 1", blocked); end
      send_frame(7, 1'b0, 1'b0);
      cfg_read(REG_FRAME_CTRL, rd);
      checks++; if (rd !== 32'hB) begin errors++;
         $display("FAIL ovf_ctrl got %h exp b", rd); end
      cfg_read(REG_FRAME_CNT, rd);
      checks++; if (rd !== 32'h4) begin errors++;
         $display("FAIL full_cnt got %h exp 4", rd); end
      for (int i = 0; i < 4; i++) begin
         cfg_read(REG_FRAME_STAT, rd);
         checks++; if (rd !== exp_stat[i]) begin errors++;
            $display("FAIL drain_stat%0d got %h exp %h", i, rd, exp_stat[i]); end
         cfg_write(REG_FRAME_POP, 32'h0);
         if (i == 0) begin
            checks++; if (blocked !== 1'b0) begin errors++;
               $display("FAIL unblock got %b exp 0", blocked); end
         end
      end
      cfg_read(REG_FRAME_STAT, rd);
      checks++; if (rd !== 32'h0) begin errors++;
         $display("FAIL empty_stat got %h exp 0", rd); end
      cfg_write(REG_FRAME_CTRL, 32'hA);
      cfg_read(REG_FRAME_CTRL, rd);
      checks++; if (rd !== 32'h2) begin errors++;
         $display("FAIL ovf_w1c got %h exp 2", rd); end
   endtask

   task automatic test_pop_push_full;
      logic [31:0] rd;
      for (int i = 1; i <= 4; i++) send_frame(i, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         byte_valid = 1'b1; @(posedge clk); #1;
      end
      byte_valid = 1'b0;
      eof = 1'b1;
      cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = REG_FRAME_POP;
      @(posedge clk); #1;
      cfg_valid_i = 1'b0; cfg_rwn_i = 1'b1; eof = 1'b0;
      @(posedge clk); #1;
      cfg_read(REG_FRAME_CTRL, rd);
      checks++; if (rd !== 32'h3) begin errors++;
         $display("FAIL pp_ctrl got %h exp 3", rd); end
      cfg_read(REG_FRAME_CNT, rd);
      checks++; if (rd !== 32'h4) begin errors++;
         $display("FAIL pp_cnt got %h exp 4", rd); end
      cfg_read(REG_FRAME_STAT, rd);
      checks++; if (rd !== 32'h80000002) begin errors++;
         $display("FAIL pp_head got %h exp 80000002", rd); end
      repeat (3) cfg_write(REG_FRAME_POP, 32'h0);
      cfg_read(REG_FRAME_STAT, rd);
      checks++; if (rd !== 32'h80000005) begin errors++;
         $display("FAIL pp_tail got %h exp 80000005", rd); end
      cfg_write(REG_FRAME_POP, 32'h0);
   endtask

   task automatic test_flush;
      logic [31:0] rd;
      for (int i = 0; i < 5; i++) send_frame(1, 1'b0, 1'b0);
      cfg_write(REG_FRAME_POP, 32'h0);
      for (int i = 0; i < 3; i++) begin
         byte_valid = 1'b1; @(posedge clk); #1;
      end
      byte_valid = 1'b0;
      cfg_write(REG_FRAME_CTRL, 32'h6);
      checks++; if (blocked !== 1'b0 || irq !== 1'b0) begin errors++;
         $display("FAIL flush_out blocked=%b irq=%b exp 0 0", blocked, irq); end
      cfg_read(REG_FRAME_CNT, rd);
      checks++; if (rd !== 32'h0) begin errors++;
         $display("FAIL flush_cnt got %h exp 0", rd); end
      cfg_read(REG_FRAME_CTRL, rd);
      checks++; if (rd !== 32'h2) begin errors++;
         $display("FAIL flush_ctrl got %h exp 2", rd); end
      send_frame(9, 1'b0, 1'b0);
      cfg_read(REG_FRAME_STAT, rd);
      checks++; if (rd !== 32'h80000009) begin errors++;
         $display("FAIL flush_len got %h exp 80000009", rd); end
      cfg_write(REG_FRAME_POP, 32'h0);
      cfg_write(REG_FRAME_POP, 32'h0);
      cfg_read(REG_FRAME_CNT, rd);
      checks++; if (rd !== 32'h0) begin errors++;
         $display("FAIL underflow_cnt got %h exp 0", rd); end
      send_frame(2, 1'b0, 1'b0);
      cfg_read(REG_FRAME_STAT, rd);
      checks++; if (rd !== 32'h80000002) begin errors++;
         $display("FAIL after_underflow got %h exp 80000002", rd); end
      cfg_write(REG_FRAME_POP, 32'h0);
   endtask

   task automatic test_cfg;
      logic [31:0] rd;
      cfg_write(REG_RX_CFG, 32'h51);
      checks++; if (rx_en_o !== 1'b1 || rx_clr_o !== 1'b1 || rx_cont !== 1'b1) begin errors++;
         $display("FAIL rx_pulse en=%b clr=%b cont=%b exp 1 1 1", rx_en_o, rx_clr_o, rx_cont); end
      @(posedge clk); #1;
      checks++; if (rx_en_o !== 1'b0 || rx_clr_o !== 1'b0) begin errors++;
         $display("FAIL rx_pulse_end en=%b clr=%b exp 0 0", rx_en_o, rx_clr_o); end
      rx_en_i = 1'b1; rx_pend_i = 1'b1;
      cfg_read(REG_RX_CFG, rd);
      checks++; if (rd !== 32'h31) begin errors++;
         $display("FAIL rx_cfg_rd got %h exp 31", rd); end
      cfg_write(REG_TX_CFG, 32'h10);
      checks++; if (tx_en_o !== 1'b1 || tx_clr_o !== 1'b0 || tx_cont !== 1'b0) begin errors++;
         $display("FAIL tx_pulse en=%b clr=%b cont=%b exp 1 0 0", tx_en_o, tx_clr_o, tx_cont); end
      cfg_write(REG_RX_SADDR, 32'h123);
      rx_curr = 12'hABC;
      checks++; if (rx_sa !== 12'h123) begin errors++;
         $display("FAIL rx_saddr got %h exp 123", rx_sa); end
      cfg_read(REG_RX_SADDR, rd);
      checks++; if (rd !== 32'hABC) begin errors++;
         $display("FAIL rx_curr got %h exp abc", rd); end
      fifo_el = 11'd1024;
      cfg_read(REG_FIFO_FULL, rd);
      checks++; if (rd !== 32'h1) begin errors++;
         $display("FAIL fifo_full got %h exp 1", rd); end
      cfg_read(REG_FIFO_N, rd);
      checks++; if (rd !== 32'd1024) begin errors++;
         $display("FAIL fifo_n got %h exp 400", rd); end
      fifo_el = 11'd1023;
      cfg_read(REG_FIFO_FULL, rd);
      checks++; if (rd !== 32'h0) begin errors++;
         $display("FAIL fifo_notfull got %h exp 0", rd); end
      cfg_read(5'h1F, rd);
      checks++; if (rd !== 32'h0) begin errors++;
         $display("FAIL unmapped got %h exp 0", rd); end
   endtask

   task automatic test_reset_eof_high;
      logic [31:0] rd;
      eof = 1'b1; rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      cfg_read(REG_FRAME_CNT, rd);
      checks++; if (rd !== 32'h0) begin errors++;
         $display("FAIL eof_at_reset cnt got %h exp 0", rd); end
      cfg_read(REG_FRAME_CTRL, rd);
      checks++; if (rd !== 32'h0) begin errors++;
         $display("FAIL reset_ctrl got %h exp 0", rd); end
      eof = 1'b0; @(posedge clk); #1;
      eof = 1'b1; @(posedge clk); #1;
      eof = 1'b0;
      cfg_read(REG_FRAME_STAT, rd);
      checks++; if (rd !== 32'h80000000) begin errors++;
         $display("FAIL zero_len got %h exp 80000000", rd); end
   endtask

   initial begin
      test_reset;
      test_single_frame;
      test_queue_full;
      test_pop_push_full;
      test_flush;
      test_cfg;
      test_reset_eof_high;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
